// File: rtl/wb_slave_interface_pkg.sv
// Shared definitions for Wishbone classic slave blocks: FSM encodings and timeout defaults.
package wb_slave_interface_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'h0,
    StReq  = 2'h1,
    StAck  = 2'h2,
    StErr  = 2'h3
  } wb_state_e;

  localparam int unsigned DefaultTimeout = 16;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned TimeoutCntW    = 8;

`ifdef SIM
  function automatic string state_name(wb_state_e s);
    case (s)
      StIdle:  return "IDLE";
      StReq:   return "REQ";
      StAck:   return "ACK";
      default: return "ERR";
    endcase
  endfunction
`endif

endpackage

// File: rtl/wb_slave_timeout.sv
// Saturating cycle counter that flags when a local request has waited TIMEOUT cycles.
module wb_slave_timeout
  import wb_slave_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TimeoutCntW-1:0] Limit = TimeoutCntW'(TIMEOUT - 1);

  logic [TimeoutCntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == Limit);

endmodule

// File: rtl/wb_slave_interface.sv
// Wishbone classic-cycle slave bridging to a req/ack local register bus, with address
// window decode, byte-select sanity check and timeout-generated error termination.
module wb_slave_interface
  import wb_slave_interface_pkg::*;
#(
  parameter int unsigned    dw        = 32,
  parameter int unsigned    aw        = 32,
  parameter logic [aw-1:0]  BASE_ADDR = '0,
  parameter int unsigned    LW        = 8,
  parameter int unsigned    TIMEOUT   = DefaultTimeout
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic          reg_req,
  output logic [LW-3:0] reg_addr,
  output logic [dw-1:0] reg_wdata,
  output logic [3:0]    reg_sel,
  output logic          reg_we,
  input  logic [dw-1:0] reg_rdata,
  input  logic          reg_ack
);

  wb_state_e r_state, w_state_next;

  logic          r_ack, r_err, r_abort, r_we;
  logic [dw-1:0] r_dat, r_wdata;
  logic [LW-3:0] r_addr;
  logic [3:0]    r_sel;

  logic w_hit, w_start, w_abort, w_expired, w_unused;

  assign w_hit    = (wb_adr_i[aw-1:LW] == BASE_ADDR[aw-1:LW]);
  assign w_start  = wb_cyc_i & wb_stb_i;
  // An abort is remembered so the backend's late completion is swallowed silently.
  assign w_abort  = r_abort | ~wb_cyc_i;
  assign w_unused = ^wb_adr_i[1:0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = (w_hit && (wb_sel_i != 4'h0)) ? StReq : StErr;
        end
      end
      StReq: begin
        if (reg_ack || w_expired) begin
          if (w_abort)      w_state_next = StIdle;
          else if (reg_ack) w_state_next = StAck;
          else              w_state_next = StErr;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_state <= StIdle;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_dat   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= (w_state_next == StAck);
      r_err   <= (w_state_next == StErr);
      r_abort <= (r_state == StReq) && (w_state_next == StReq) && w_abort;
      if ((r_state == StIdle) && w_start) begin
        r_addr  <= wb_adr_i[LW-1:2];
        r_wdata <= wb_dat_i;
        r_sel   <= wb_sel_i;
        r_we    <= wb_we_i;
      end
      if ((r_state == StReq) && reg_ack && !w_abort && !r_we) begin
        r_dat <= reg_rdata;
      end
    end
  end

  wb_slave_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (wb_clk),
    .i_rst_n   (wb_rst_n),
    .i_clr     (r_state == StIdle),
    .i_en      (r_state == StReq),
    .o_expired (w_expired)
  );

  assign wb_dat_o  = r_dat;
  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_rty_o  = 1'b0;
  assign reg_req   = (r_state == StReq);
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_sel   = r_sel;
  assign reg_we    = r_we;

`ifdef SIM
  string w_state_name;
  assign w_state_name = state_name(r_state);
`endif

endmodule

// File: tb/tb_wb_slave_interface.sv
// Directed self-checking bench for wb_slave_interface; window is 0x1000..0x10FF.
module tb_wb_slave_interface;

  localparam logic [31:0] Base = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_i, dat_o, rdata, wdata;
  logic [3:0]  sel, rsel;
  logic        we, cyc, stb, ack_o, err_o, rty_o;
  logic        req, rwe, tb_ack, zero_wait;
  logic        ack_in;
  logic [5:0]  raddr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ack_in = zero_wait ? req : tb_ack;

  wb_slave_interface #(
    .dw        (32),
    .aw        (32),
    .BASE_ADDR (Base),
    .LW        (8),
    .TIMEOUT   (16)
  ) dut (
    .wb_clk    (clk),
    .wb_rst_n  (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack_o),
    .wb_err_o  (err_o),
    .wb_rty_o  (rty_o),
    .reg_req   (req),
    .reg_addr  (raddr),
    .reg_wdata (wdata),
    .reg_sel   (rsel),
    .reg_we    (rwe),
    .reg_rdata (rdata),
    .reg_ack   (ack_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d);
    adr = a; we = w; sel = s; dat_i = d; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ack_o, err_o, rty_o, req, rwe} !== 5'b0)
      begin $display("FAIL reset_ctrl: got %b want 00000", {ack_o, err_o, rty_o, req, rwe});
      n_fail++; end
    n_checks++;
    if ({dat_o, wdata, raddr, rsel} !== '0)
      begin $display("FAIL reset_data: got %h want 0", {dat_o, wdata, raddr, rsel}); n_fail++; end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_hit();
    zero_wait = 1'b1;
    rdata = 32'hDEAD_BEEF;
    issue(Base + 32'h10, 1'b0, 4'hF, 32'h0);
    tick();
    n_checks++;
    if (req !== 1'b1 || raddr !== 6'd4)
      begin $display("FAIL rd_req: got req=%b addr=%0d want 1/4", req, raddr); n_fail++; end
    n_checks++;
    if (ack_o !== 1'b0) begin $display("FAIL rd_early_ack: got %b want 0", ack_o); n_fail++; end
    tick();
    n_checks++;
    if (ack_o !== 1'b1) begin $display("FAIL rd_ack: got %b want 1", ack_o); n_fail++; end
    n_checks++;
    if (dat_o !== 32'hDEAD_BEEF)
      begin $display("FAIL rd_data: got %h want deadbeef", dat_o); n_fail++; end
    release_bus();
    tick();
    n_checks++;
    if (ack_o !== 1'b0 || req !== 1'b0)
      begin $display("FAIL rd_idle: got ack=%b req=%b want 0/0", ack_o, req); n_fail++; end
    zero_wait = 1'b0;
  endtask

  task automatic test_write_wait();
    int acks = 0;
    tb_ack = 1'b0;
    rdata = 32'hCAFE_0000;
    issue(Base + 32'h20, 1'b1, 4'b0011, 32'h1234_5678);
    tick();
    n_checks++;
    if (req !== 1'b1 || rwe !== 1'b1 || rsel !== 4'h3 || wdata !== 32'h1234_5678)
      begin $display("FAIL wr_req: got req=%b we=%b sel=%h wd=%h want 1/1/3/12345678",
                     req, rwe, rsel, wdata); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack_o) acks++;
    end
    n_checks++;
    if (req !== 1'b1 || acks != 0)
      begin $display("FAIL wr_wait: got req=%b acks=%0d want 1/0", req, acks); n_fail++; end
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    n_checks++;
    if (ack_o !== 1'b1) begin $display("FAIL wr_ack: got %b want 1", ack_o); n_fail++; end
    release_bus();
    tick();
    n_checks++;
    if (ack_o !== 1'b0) begin $display("FAIL wr_ack_pulse: got %b want 0", ack_o); n_fail++; end
    n_checks++;
    if (dat_o !== 32'hDEAD_BEEF)
      begin $display("FAIL wr_dat_hold: got %h want deadbeef", dat_o); n_fail++; end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    logic [3:0]  sels  [2];
    addrs[0] = 32'h0000_2000; sels[0] = 4'hF;
    addrs[1] = Base + 32'h04;  sels[1] = 4'h0;
    for (int i = 0; i < 2; i++) begin
      issue(addrs[i], 1'b0, sels[i], 32'h0);
      tick();
      n_checks++;
      if (err_o !== 1'b1 || req !== 1'b0 || ack_o !== 1'b0)
        begin $display("FAIL dec_err%0d: got err=%b req=%b ack=%b want 1/0/0",
                       i, err_o, req, ack_o); n_fail++; end
      release_bus();
      tick();
      n_checks++;
      if (err_o !== 1'b0 || req !== 1'b0)
        begin $display("FAIL dec_idle%0d: got err=%b req=%b want 0/0", i, err_o, req); n_fail++; end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_at = -1;
    int acks = 0;
    tb_ack = 1'b0;
    issue(Base + 32'h08, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req) req_cycles++;
      if (ack_o) acks++;
      if (err_o) begin
        err_at = i;
        break;
      end
    end
    n_checks++;
    if (err_at != 16) begin $display("FAIL to_err_time: got %0d want 16", err_at); n_fail++; end
    n_checks++;
    if (req_cycles != 16 || acks != 0)
      begin $display("FAIL to_req_cycles: got %0d acks=%0d want 16/0", req_cycles, acks);
      n_fail++; end
    release_bus();
    tick();
    n_checks++;
    if (err_o !== 1'b0 || req !== 1'b0)
      begin $display("FAIL to_idle: got err=%b req=%b want 0/0", err_o, req); n_fail++; end
  endtask

  task automatic test_abort();
    tb_ack = 1'b0;
    rdata = 32'h5555_AAAA;
    issue(Base + 32'h0C, 1'b0, 4'hF, 32'h0);
    tick();
    release_bus();
    tick();
    tick();
    n_checks++;
    if (req !== 1'b1) begin $display("FAIL ab_req_held: got %b want 1", req); n_fail++; end
    tb_ack = 1'b1;
    tick();
    tb_ack = 1'b0;
    n_checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || req !== 1'b0)
      begin $display("FAIL ab_suppress: got ack=%b err=%b req=%b want 0/0/0",
                     ack_o, err_o, req); n_fail++; end
    tick();
    n_checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0)
      begin $display("FAIL ab_late: got ack=%b err=%b want 0/0", ack_o, err_o); n_fail++; end
  endtask

  task automatic test_reset_mid();
    tb_ack = 1'b0;
    issue(Base + 32'h40, 1'b1, 4'hC, 32'hA5A5_A5A5);
    tick();
    n_checks++;
    if (req !== 1'b1) begin $display("FAIL rm_req: got %b want 1", req); n_fail++; end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({dat_o, wdata, raddr, rsel, ack_o, err_o, req, rwe} !== '0)
      begin $display("FAIL rm_outputs: got %h want 0",
                     {dat_o, wdata, raddr, rsel, ack_o, err_o, req, rwe}); n_fail++; end
    rst_n = 1'b1;
    release_bus();
    tick();
    n_checks++;
    if (req !== 1'b0 || ack_o !== 1'b0)
      begin $display("FAIL rm_idle: got req=%b ack=%b want 0/0", req, ack_o); n_fail++; end
  endtask

  task automatic test_back_to_back();
    zero_wait = 1'b1;
    rdata = 32'h1111_1111;
    issue(Base + 32'h80, 1'b0, 4'hF, 32'h0);
    tick();
    tick();
    n_checks++;
    if (ack_o !== 1'b1 || dat_o !== 32'h1111_1111)
      begin $display("FAIL b2b_ack0: got ack=%b dat=%h want 1/11111111", ack_o, dat_o);
      n_fail++; end
    // Master presents the next transfer while still seeing the first ack.
    rdata = 32'h2222_2222;
    issue(Base + 32'hC4, 1'b0, 4'hF, 32'h0);
    tick();
    n_checks++;
    if (req !== 1'b0 || ack_o !== 1'b0)
      begin $display("FAIL b2b_no_double: got req=%b ack=%b want 0/0", req, ack_o); n_fail++; end
    tick();
    n_checks++;
    if (req !== 1'b1 || raddr !== 6'd49)
      begin $display("FAIL b2b_req1: got req=%b addr=%0d want 1/49", req, raddr); n_fail++; end
    tick();
    n_checks++;
    if (ack_o !== 1'b1 || dat_o !== 32'h2222_2222)
      begin $display("FAIL b2b_ack1: got ack=%b dat=%h want 1/22222222", ack_o, dat_o);
      n_fail++; end
    release_bus();
    tick();
    n_checks++;
    if (ack_o !== 1'b0 || req !== 1'b0)
      begin $display("FAIL b2b_end: got ack=%b req=%b want 0/0", ack_o, req); n_fail++; end
    zero_wait = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    rdata = '0; tb_ack = 1'b0; zero_wait = 1'b0;
    test_reset();
    test_read_hit();
    test_write_wait();
    test_decode_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
